bf_program_loader: RTL

Byte-stream program loader sitting directly upstream of the Brainfuck processor's 256-byte program/data memory. It accepts characters over a valid/ready handshake, discards everything except the eight Brainfuck opcodes, and writes the surviving opcodes into consecutive memory locations using the memory's active-low write/clear strobes. It appends a 0x00 terminator, reports program length, and flags overflow. Optionally, it also flags unbalanced brackets.

---
 rtl/bf_program_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bf_program_loader.sv
// bf_program_loader: filters a character stream down to the eight Brainfuck
// opcodes and writes them, followed by a 0x00 terminator, into the program
// memory using its active-low WE/CLR strobes.
// Optional feature macro: BF_LOADER_BRACKET_CHECK_EN (bracket balance check).
module bf_program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_LEN   = 256
) (
    input  logic        i_clk,
    input  logic        Reset,
    input  logic        i_start,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_drive,
    output logic        o_mem_oe_n,
    output logic        o_mem_we_n,
    output logic        o_mem_clr_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_prog_len
);

    localparam logic [3:0] StIdle       = 4'd0;
    localparam logic [3:0] StClear      = 4'd1;
    localparam logic [3:0] StAccept     = 4'd2;
    localparam logic [3:0] StSetup      = 4'd3;
    localparam logic [3:0] StStrobe     = 4'd4;
    localparam logic [3:0] StHold       = 4'd5;
    localparam logic [3:0] StTermSetup  = 4'd6;
    localparam logic [3:0] StTermStrobe = 4'd7;
    localparam logic [3:0] StTermHold   = 4'd8;
    localparam logic [3:0] StDone       = 4'd9;
    localparam logic [3:0] StError      = 4'd10;

    // Highest opcode count that still leaves room for the terminator.
    localparam logic [15:0] LastLen = 16'(MAX_LEN - 1);

    logic [3:0]  r_state;
    logic [3:0]  w_state_d;
    logic [15:0] r_prog_len;
    logic [15:0] w_prog_len_d;
    logic [7:0]  r_wdata;
    logic [7:0]  w_wdata_d;

    logic w_is_op;
    logic w_is_term;
    logic w_full;
    logic w_brk_err;

    // Classify the incoming byte.
    always_comb begin
        w_is_term = (i_in_data == 8'h00) || (i_in_data == 8'h21);
        w_is_op   = 1'b0;
        case (i_in_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: w_is_op = 1'b1;
            default: w_is_op = 1'b0;
        endcase
        w_full = (r_prog_len == LastLen);
    end

`ifdef BF_LOADER_BRACKET_CHECK_EN
    logic [7:0] r_depth;
    logic [7:0] w_depth_d;
    logic       w_is_open;
    logic       w_is_close;

    // Bracket nesting violations for the byte currently offered.
    always_comb begin
        w_is_open  = (i_in_data == 8'h5B);
        w_is_close = (i_in_data == 8'h5D);
        w_brk_err  = (w_is_open && (r_depth == 8'hFF)) ||
                     (w_is_close && (r_depth == 8'h00)) ||
                     (w_is_term && (r_depth != 8'h00));
    end
`else
    // Bracket checking not built.
    always_comb begin
        w_brk_err = 1'b0;
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        w_state_d    = r_state;
        w_prog_len_d = r_prog_len;
        w_wdata_d    = r_wdata;
`ifdef BF_LOADER_BRACKET_CHECK_EN
        w_depth_d    = r_depth;
`endif
        case (r_state)
            StIdle, StDone, StError: begin
                if (i_start) begin
                    // Clear on entry so CLEAR already presents the cleared values.
                    w_state_d    = StClear;
                    w_prog_len_d = 16'd0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
                    w_depth_d    = 8'd0;
`endif
                end
            end
            StClear: w_state_d = StAccept;
            StAccept: begin
                if (i_in_valid) begin
                    if (w_is_term) begin
                        if (w_brk_err) begin
                            w_state_d = StError;
                        end else begin
                            w_state_d = StTermSetup;
                            w_wdata_d = 8'h00;
                        end
                    end else if (w_is_op) begin
                        if (w_full || w_brk_err) begin
                            w_state_d = StError;
                        end else begin
                            w_state_d = StSetup;
                            w_wdata_d = i_in_data;
`ifdef BF_LOADER_BRACKET_CHECK_EN
                            if (w_is_open) begin
                                w_depth_d = r_depth + 8'd1;
                            end else if (w_is_close) begin
                                w_depth_d = r_depth - 8'd1;
                            end
`endif
                        end
                    end
                end
            end
            StSetup:      w_state_d = StStrobe;
            StStrobe:     w_state_d = StHold;
            StHold: begin
                w_state_d    = StAccept;
                w_prog_len_d = r_prog_len + 16'd1;
            end
            StTermSetup:  w_state_d = StTermStrobe;
            StTermStrobe: w_state_d = StTermHold;
            StTermHold:   w_state_d = StDone;
            default:      w_state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!Reset) begin
            r_state    <= StIdle;
            r_prog_len <= 16'd0;
            r_wdata    <= 8'h00;
`ifdef BF_LOADER_BRACKET_CHECK_EN
            r_depth    <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_prog_len <= w_prog_len_d;
            r_wdata    <= w_wdata_d;
`ifdef BF_LOADER_BRACKET_CHECK_EN
            r_depth    <= w_depth_d;
`endif
        end
    end

    // Outputs decoded from registered state only, so strobes are glitch-free.
    always_comb begin
        o_in_ready  = (r_state == StAccept);
        o_mem_addr  = BASE_ADDR + r_prog_len;
        o_mem_wdata = r_wdata;
        o_mem_drive = (r_state == StSetup) || (r_state == StStrobe) || (r_state == StHold) ||
                      (r_state == StTermSetup) || (r_state == StTermStrobe) ||
                      (r_state == StTermHold);
        o_mem_oe_n  = 1'b1;
        o_mem_we_n  = !((r_state == StStrobe) || (r_state == StTermStrobe));
        o_mem_clr_n = (r_state != StClear);
        o_busy      = !((r_state == StIdle) || (r_state == StDone) || (r_state == StError));
        o_done      = (r_state == StDone);
        o_error     = (r_state == StError);
        o_prog_len  = r_prog_len;
    end

endmodule
